// File: rtl/stream_checker.sv
// Sink for the valid/ready channel: checks for an incrementing word sequence,
// counts accepted words and sequence errors, and can throttle ready with an LFSR.
module stream_checker #(
  parameter int          WIDTH       = 8,
  parameter int          COUNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   throttle,
  input  logic [WIDTH-1:0]       idata,
  input  logic                   ivalid,
  output logic                   iready,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] errors,
  output logic [WIDTH-1:0]       last_data,
  output logic                   locked,
  output logic                   error
);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {HUNT, TRACK} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   iready_q, iready_d;
  logic [WIDTH-1:0]       exp_q, exp_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] errors_q, errors_d;
  logic [WIDTH-1:0]       last_q, last_d;
  logic                   error_q, error_d;
  logic                   xfer;

  assign xfer = ivalid && iready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)     state_d = HUNT;
    else if (xfer) state_d = TRACK;
  end

  always_comb begin
    locked = (state_q == TRACK);
  end

  // Clear takes priority over a coinciding transfer, so that word is dropped.
  always_comb begin
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    iready_d = clear ? 1'b0 : (throttle ? lfsr_q[0] : 1'b1);
    exp_d    = exp_q;
    count_d  = count_q;
    errors_d = errors_q;
    last_d   = last_q;
    error_d  = 1'b0;
    if (clear) begin
      count_d  = '0;
      errors_d = '0;
    end else if (xfer) begin
      last_d  = idata;
      count_d = count_q + COUNT_WIDTH'(1);
      exp_d   = idata + WIDTH'(1);
      if (state_q == TRACK && idata != exp_q) begin
        error_d = 1'b1;
        if (errors_q != '1) errors_d = errors_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q   <= SeedEff;
      iready_q <= 1'b0;
      exp_q    <= '0;
      count_q  <= '0;
      errors_q <= '0;
      last_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      iready_q <= iready_d;
      exp_q    <= exp_d;
      count_q  <= count_d;
      errors_q <= errors_d;
      last_q   <= last_d;
      error_q  <= error_d;
    end
  end

  assign iready    = iready_q;
  assign count     = count_q;
  assign errors    = errors_q;
  assign last_data = last_q;
  assign error     = error_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed self-checking bench for stream_checker: sequence, wrap, resync,
// LFSR throttling, clear collision and asynchronous reset.
module tb_stream_checker;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        throttle;
  logic [7:0]  idata;
  logic        ivalid;
  logic        iready;
  logic [15:0] count;
  logic [15:0] errors;
  logic [7:0]  last_data;
  logic        locked;
  logic        error;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model of the ready register and accepted-word count.
  logic [15:0] mLfsr;
  logic        mReady;
  int          mCount;
  logic        lastXfer;

  stream_checker dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .throttle (throttle),
    .idata    (idata),
    .ivalid   (ivalid),
    .iready   (iready),
    .count    (count),
    .errors   (errors),
    .last_data(last_data),
    .locked   (locked),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // One clock cycle: drive inputs, take the edge, advance the model, settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic clr);
    ivalid = v;
    idata  = d;
    clear  = clr;
    @(posedge clock);
    lastXfer = v && mReady;
    if (clr)           mCount = 0;
    else if (lastXfer) mCount++;
    mReady = clr ? 1'b0 : (throttle ? mLfsr[0] : 1'b1);
    mLfsr  = lfsrStep(mLfsr);
    #1;
    clear = 1'b0;
  endtask

  task automatic modelReset();
    mLfsr  = 16'hACE1;
    mReady = 1'b0;
    mCount = 0;
  endtask

  initial begin
    int sent;
    reset = 1'b1; clear = 1'b0; throttle = 1'b0; idata = 8'h00; ivalid = 1'b0;
    modelReset();
    #12;
    checkOutput("rst_iready", iready, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_last", last_data, 0);
    reset = 1'b0;

    // Basic stream 00..0F
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("first_ready", iready, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("basic_locked", locked, 1);
      checkOutput("basic_error", error, 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("basic_count", count, 16);
    checkOutput("basic_errors", errors, 0);
    checkOutput("basic_last", last_data, 8'h0F);

    // Wrap FE FF 00 01
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFE, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("wrap_error", error, 0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wrap_count", count, 4);
    checkOutput("wrap_errors", errors, 0);

    // Mismatch and resync: 10 11 20 21
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("mm_error_pre", error, 0);
    applyStimulus(1'b1, 8'h20, 1'b0);
    checkOutput("mm_error_pulse", error, 1);
    checkOutput("mm_errors", errors, 1);
    applyStimulus(1'b1, 8'h21, 1'b0);
    checkOutput("mm_error_post", error, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("mm_count", count, 4);
    checkOutput("mm_errors_end", errors, 1);

    // Throttled stream 00..FF, source advances only on transfer
    throttle = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    sent = 0;
    for (int cyc = 0; cyc < 4000 && sent < 256; cyc++) begin
      checkOutput("thr_iready", iready, mReady);
      applyStimulus(1'b1, 8'(sent), 1'b0);
      if (lastXfer) sent++;
      checkOutput("thr_count", count, mCount);
    end
    checkOutput("thr_done", sent, 256);
    throttle = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("thr_count_end", count, 256);
    checkOutput("thr_errors", errors, 0);
    checkOutput("thr_last", last_data, 8'hFF);

    // Clear colliding with a transfer
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("clr_pre_count", count, 5);
    applyStimulus(1'b1, 8'h05, 1'b1);
    checkOutput("clr_count", count, 0);
    checkOutput("clr_errors", errors, 0);
    checkOutput("clr_locked", locked, 0);
    checkOutput("clr_iready", iready, 0);
    checkOutput("clr_last_held", last_data, 8'h04);
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("clr_no_xfer", count, 0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkOutput("clr_relock", locked, 1);
    checkOutput("clr_relock_err", error, 0);
    checkOutput("clr_relock_cnt", count, 1);

    // Asynchronous reset between edges, mid-stream
    applyStimulus(1'b1, 8'h50, 1'b0);
    applyStimulus(1'b1, 8'h51, 1'b0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("arst_count", count, 0);
    checkOutput("arst_locked", locked, 0);
    checkOutput("arst_iready", iready, 0);
    checkOutput("arst_last", last_data, 0);
    checkOutput("arst_error", error, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("arst_first_err", error, 0);
    checkOutput("arst_first_cnt", count, 1);
    checkOutput("arst_first_lock", locked, 1);
    applyStimulus(1'b1, 8'h78, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("arst_count2", count, 2);
    checkOutput("arst_errors", errors, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
